spi_master: RTL and testbench



---
 rtl/spi_master.sv | 156 +++++++++++++++
 tb/tb_spi_master.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI master with a small CPU register window. A TX write launches one LSB-first
// frame framed by PAD_CLKS idle sclk pulses (ss high) on each side.
module spi_master #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 3,
    parameter int CLK_DIV  = 4,
    parameter int PAD_CLKS = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              sclk,
    output logic              ss,
    output logic              mosi,
    input  logic              miso,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    input  logic [ADDR_W-1:0] address,
    input  logic              sel,
    input  logic              read,
    input  logic              write
);
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int PAD_W = $clog2(PAD_CLKS + 1);

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [PAD_W-1:0] PAD_LAST = PAD_W'(PAD_CLKS - 1);

    localparam logic [ADDR_W-1:0] A_READY    = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_TX       = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_RX       = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_VERSION  = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_SOFT_RST = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_DUMMY    = ADDR_W'(5);

    typedef enum logic [1:0] {IDLE, PRE, XFER, POST} state_t;

    state_t            state;
    state_t            next_state;
    logic [DIV_W-1:0]  div_cnt;
    logic [PAD_W-1:0]  pad_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] rx_shift;
    logic [DATA_W-1:0] rx_reg;
    logic [DATA_W-1:0] dummy;
    logic              ready;
    logic              busy;

    logic soft_rst;
    logic rst_all;
    logic tx_wr;
    logic rx_rd;
    logic dummy_wr;
    logic tick;
    logic rise;
    logic fall;
    logic done;

    // A soft-reset write behaves exactly like rst on the edge that samples it.
    assign soft_rst = sel & write & (address == A_SOFT_RST);
    assign rst_all  = rst | soft_rst;
    assign tx_wr    = sel & write & (address == A_TX);
    assign rx_rd    = sel & read & (address == A_RX);
    assign dummy_wr = sel & write & (address == A_DUMMY);

    assign tick = (state != IDLE) && (div_cnt == DIV_LAST);
    assign rise = tick & ~sclk;
    assign fall = tick & sclk;
    assign done = (state == POST) && fall && (pad_cnt == PAD_LAST);

    always_ff @(posedge clk) begin
        if (rst_all) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (tx_wr) next_state = PRE;
            PRE:  if (fall && (pad_cnt == PAD_LAST)) next_state = XFER;
            XFER: if (fall && (bit_cnt == BIT_LAST)) next_state = POST;
            POST: if (done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        ss   = (state != XFER);
        mosi = (state == XFER) & tx_shift[0];
    end

    // Pad pulses are counted on falling sclk edges, so each phase ends with sclk low.
    always_ff @(posedge clk) begin
        if (rst_all) begin
            sclk     <= 1'b0;
            div_cnt  <= '0;
            pad_cnt  <= '0;
            bit_cnt  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
        end else if (state == IDLE) begin
            sclk    <= 1'b0;
            div_cnt <= '0;
            pad_cnt <= '0;
            bit_cnt <= '0;
            if (tx_wr) tx_shift <= data_in;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            if (tick) sclk <= ~sclk;
            if (fall && (state != XFER)) begin
                pad_cnt <= (pad_cnt == PAD_LAST) ? '0 : pad_cnt + PAD_W'(1);
            end
            if ((state == XFER) && rise) begin
                rx_shift <= {miso, rx_shift[DATA_W-1:1]};
                bit_cnt  <= bit_cnt + BIT_W'(1);
            end
            if ((state == XFER) && fall && (bit_cnt != BIT_LAST)) begin
                tx_shift <= tx_shift >> 1;
            end
        end
    end

    // Completion setting ready takes priority over a same-cycle RX read-clear.
    always_ff @(posedge clk) begin
        if (rst_all) begin
            rx_reg <= '0;
            ready  <= 1'b0;
            dummy  <= '0;
        end else begin
            if (done) begin
                rx_reg <= rx_shift;
                ready  <= 1'b1;
            end else if (rx_rd) begin
                ready <= 1'b0;
            end
            if (dummy_wr) dummy <= data_in;
        end
    end

    always_comb begin
        data_out = '0;
        case (address)
            A_READY:   data_out = DATA_W'({busy, ready});
            A_RX:      data_out = rx_reg;
            A_VERSION: data_out = DATA_W'(32'h0001_0000);
            A_DUMMY:   data_out = dummy;
            default:   data_out = '0;
        endcase
    end
endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: stimulus queues expected reads, pin states and
// frames; a negedge monitor pops and compares them against what the DUT shows.
module tb_spi_master;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 3;
    localparam int CLK_DIV  = 4;
    localparam int PAD_CLKS = 4;
    localparam int LAT      = 2 * CLK_DIV * (2 * PAD_CLKS + DATA_W);

    localparam logic [ADDR_W-1:0] A_READY    = 3'd0;
    localparam logic [ADDR_W-1:0] A_TX       = 3'd1;
    localparam logic [ADDR_W-1:0] A_RX       = 3'd2;
    localparam logic [ADDR_W-1:0] A_VERSION  = 3'd3;
    localparam logic [ADDR_W-1:0] A_SOFT_RST = 3'd4;
    localparam logic [ADDR_W-1:0] A_DUMMY    = 3'd5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sclk;
    logic              ss;
    logic              mosi;
    logic              miso;
    logic [DATA_W-1:0] data_in = '0;
    logic [DATA_W-1:0] data_out;
    logic [ADDR_W-1:0] address = '0;
    logic              sel = 1'b0;
    logic              read = 1'b0;
    logic              write = 1'b0;

    logic        loop_mode = 1'b1;
    logic        slave_miso = 1'b0;
    logic [31:0] slave_word = '0;

    assign miso = loop_mode ? mosi : slave_miso;

    always #5 clk = ~clk;

    spi_master #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CLK_DIV(CLK_DIV), .PAD_CLKS(PAD_CLKS)
    ) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso),
        .data_in(data_in), .data_out(data_out), .address(address),
        .sel(sel), .read(read), .write(write)
    );

    typedef struct { logic [31:0] data; string name; } rd_exp_t;
    typedef struct { logic [31:0] word; bit body; } fr_exp_t;
    typedef struct { logic sclk; logic ss; logic mosi; string name; } pin_exp_t;

    rd_exp_t  rd_q[$];
    fr_exp_t  fr_q[$];
    pin_exp_t pin_q[$];

    int checks = 0;
    int errors = 0;
    bit done = 1'b0;

    // Reference model: what the CPU should see, independent of how the RTL sequences it.
    logic [31:0] ref_rx = '0;
    logic        ref_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops read, pin and frame expectations when the DUT presents them.
    rd_exp_t     rexp;
    fr_exp_t     fexp;
    pin_exp_t    pexp;
    int          phase = 0;
    int          pre_cnt = 0;
    int          post_cnt = 0;
    int          rise_cnt = 0;
    int          low_run = 0;
    logic [31:0] mosi_word = '0;
    logic        prev_sclk = 1'b0;
    logic        prev_ss = 1'b1;

    always @(negedge clk) begin
        if (pin_q.size() > 0) begin
            pexp = pin_q.pop_front();
            check({pexp.name, "_sclk"}, 32'(sclk), 32'(pexp.sclk));
            check({pexp.name, "_ss"}, 32'(ss), 32'(pexp.ss));
            check({pexp.name, "_mosi"}, 32'(mosi), 32'(pexp.mosi));
        end
        if (sel && read) begin
            if (rd_q.size() == 0) begin
                check("read_expected", 32'(rd_q.size()), 32'd1);
            end else begin
                rexp = rd_q.pop_front();
                check(rexp.name, data_out, rexp.data);
            end
        end
        if (!rst) begin
            if (!ss && prev_ss) begin
                phase = 2; rise_cnt = 0; mosi_word = '0;
            end
            if (ss && !prev_ss && phase == 2) begin
                phase = 3; post_cnt = 0;
            end
            if (sclk && !prev_sclk) begin
                if (!ss) begin
                    if (rise_cnt < 32) mosi_word = mosi_word | (32'(mosi) << rise_cnt);
                    rise_cnt++;
                end else if (phase == 0) begin
                    phase = 1; pre_cnt = 1;
                end else if (phase == 1) begin
                    pre_cnt++;
                end else if (phase == 3) begin
                    post_cnt++;
                end
            end
            low_run = sclk ? 0 : low_run + 1;
            if (phase == 3 && low_run > 2 * CLK_DIV + 1) begin
                phase = 0;
                if (fr_q.size() == 0) begin
                    check("frame_expected", 32'(fr_q.size()), 32'd1);
                end else begin
                    fexp = fr_q.pop_front();
                    check("frame_pre_pulses", 32'(pre_cnt), 32'(PAD_CLKS));
                    if (fexp.body) begin
                        check("frame_ss_low_rises", 32'(rise_cnt), 32'(DATA_W));
                        check("frame_mosi_lsb_first", mosi_word, fexp.word);
                        check("frame_post_pulses", 32'(post_cnt), 32'(PAD_CLKS));
                    end
                end
            end
        end
        prev_sclk = sclk;
        prev_ss = ss;
        if (done) begin
            check("pending_reads", 32'(rd_q.size()), 32'd0);
            check("pending_frames", 32'(fr_q.size()), 32'd0);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    // Slave model: presents bit 0 when ss falls, the next bit on each sclk fall.
    logic s_prev_sclk = 1'b0;
    logic s_prev_ss = 1'b1;
    int   s_idx = 0;

    always @(negedge clk) begin
        if (!ss && s_prev_ss) begin
            slave_miso = slave_word[0];
            s_idx = 1;
        end else if (!ss && s_prev_sclk && !sclk) begin
            if (s_idx < 32) slave_miso = slave_word[s_idx];
            s_idx++;
        end
        s_prev_sclk = sclk;
        s_prev_ss = ss;
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input logic [31:0] data);
        sel = 1'b1; write = 1'b1; read = 1'b0; address = addr; data_in = data;
        @(posedge clk);
        #1;
        sel = 1'b0; write = 1'b0;
    endtask

    task automatic checkOutput(input logic [ADDR_W-1:0] addr, input logic [31:0] exp,
                               input string name);
        rd_exp_t e;
        e.data = exp;
        e.name = name;
        rd_q.push_back(e);
        sel = 1'b1; read = 1'b1; write = 1'b0; address = addr;
        @(posedge clk);
        #1;
        sel = 1'b0; read = 1'b0;
    endtask

    task automatic checkPins(input logic s, input logic q, input logic m, input string name);
        pin_exp_t e;
        e.sclk = s; e.ss = q; e.mosi = m; e.name = name;
        pin_q.push_back(e);
    endtask

    task automatic startFrame(input logic [31:0] tx, input bit body);
        fr_exp_t e;
        e.word = tx;
        e.body = body;
        fr_q.push_back(e);
        applyStimulus(A_TX, tx);
    endtask

    // One full frame with exact completion timing; consume selects whether RX is read at the end.
    task automatic runFrame(input logic [31:0] tx, input bit consume);
        logic [31:0] exp_rx;
        exp_rx = loop_mode ? tx : slave_word;
        startFrame(tx, 1'b1);
        checkOutput(A_READY, 32'({1'b1, ref_ready}), "busy_at_start");
        checkOutput(A_RX, ref_rx, "rx_unchanged_mid_frame");
        ref_ready = 1'b0;
        waitCycles(LAT - 3);
        checkOutput(A_READY, 32'd2, "busy_before_done");
        ref_rx = exp_rx;
        ref_ready = 1'b1;
        checkOutput(A_READY, 32'd1, "ready_at_latency");
        if (consume) begin
            checkOutput(A_RX, ref_rx, "rx_word");
            ref_ready = 1'b0;
            checkOutput(A_READY, 32'd0, "ready_cleared");
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [31:0] tx;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkPins(1'b0, 1'b1, 1'b0, "reset_pins");
        checkOutput(A_READY, 32'd0, "reset_ready");
        checkOutput(A_VERSION, 32'h0001_0000, "version");

        loop_mode = 1'b1;
        runFrame(32'hA5C3_0F01, 1'b1);
        waitCycles(20);

        loop_mode = 1'b0;
        slave_word = 32'h1234_5678;
        tx = $urandom;
        runFrame(tx, 1'b1);
        waitCycles(20);

        for (int i = 0; i < 4; i++) begin
            loop_mode = 1'($urandom_range(0, 1));
            slave_word = $urandom;
            tx = $urandom;
            runFrame(tx, (i != 1));
            waitCycles(20);
        end

        // A TX write while busy must not disturb the all-zero frame in flight.
        loop_mode = 1'b1;
        startFrame(32'h0, 1'b1);
        checkOutput(A_READY, 32'({1'b1, ref_ready}), "busy_zero_frame");
        waitCycles(99);
        applyStimulus(A_TX, 32'hFFFF_FFFF);
        waitCycles(LAT - 102);
        checkOutput(A_READY, 32'({1'b1, ref_ready}), "busy_before_done_zero");
        ref_rx = 32'h0;
        ref_ready = 1'b1;
        checkOutput(A_READY, 32'd1, "ready_zero_frame");
        checkOutput(A_RX, 32'h0, "rx_zero_frame");
        ref_ready = 1'b0;
        waitCycles(20);

        applyStimulus(A_DUMMY, 32'hDEAD_BEEF);
        checkOutput(A_DUMMY, 32'hDEAD_BEEF, "dummy_readback");

        // Soft reset on the edge of the 10th rising sclk inside XFER.
        loop_mode = 1'b0;
        slave_word = $urandom;
        startFrame($urandom, 1'b0);
        waitCycles(107);
        applyStimulus(A_SOFT_RST, 32'h0);
        checkPins(1'b0, 1'b1, 1'b0, "softrst_pins");
        ref_rx = 32'h0;
        ref_ready = 1'b0;
        checkOutput(A_READY, 32'd0, "softrst_ready");
        checkOutput(A_RX, 32'h0, "softrst_rx");
        checkOutput(A_DUMMY, 32'h0, "softrst_dummy");
        waitCycles(20);
        tx = $urandom;
        runFrame(tx, 1'b1);
        waitCycles(20);

        // RX read-clear lands on the completion edge: the set must win.
        loop_mode = 1'b1;
        tx = $urandom;
        startFrame(tx, 1'b1);
        waitCycles(LAT - 1);
        checkOutput(A_RX, ref_rx, "rx_old_at_collision");
        ref_rx = tx;
        ref_ready = 1'b1;
        checkOutput(A_READY, 32'd1, "ready_after_collision");
        checkOutput(A_RX, ref_rx, "rx_after_collision");
        ref_ready = 1'b0;
        checkOutput(A_READY, 32'd0, "ready_cleared_after_collision");

        checkOutput(3'd6, 32'h0, "unmapped_read");
        applyStimulus(3'd7, 32'h1234_5678);
        checkOutput(3'd7, 32'h0, "unmapped_write_ignored");

        waitCycles(20);
        done = 1'b1;
    end
endmodule
